// File: rtl/usr_pkg.sv
// usr_pkg: shared types and constants for the USR serial link receiver.
//   state_t        : receiver FSM states (ST_IDLE, ST_SHIFT)
//   DIR_LSB_FIRST  : frame arrives LSB first (USR shift-right source)
//   DIR_MSB_FIRST  : frame arrives MSB first (USR shift-left source)
package usr_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: WIDTH-bit deserializing shift register.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   clr        : zero the register (new frame)
//   en         : shift sin in this cycle
//   dir        : DIR_LSB_FIRST shifts in at the top, DIR_MSB_FIRST at the bottom
//   sin        : serial bit
//   sh_next    : register value after this cycle's shift, so the parent can
//                capture the completed word on the same edge as the last bit
module deser_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] sh_next
);
   logic [WIDTH-1:0] sh;

   always_comb begin
      sh_next = sh;
      if (en) begin
         if (dir == DIR_MSB_FIRST) sh_next = {sh[WIDTH-2:0], sin};
         else                      sh_next = {sin, sh[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)   sh <= '0;
      else if (clr) sh <= '0;
      else          sh <= sh_next;
   end
endmodule

// File: rtl/usr_deser.sv
// usr_deser: serial-to-parallel receiver with a one-entry valid/ready buffer.
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   start, dir      : frame start pulse; dir latched with it
//   sin, sin_valid  : strobed serial data
//   q, q_valid      : received word and its valid flag
//   q_ready         : consumer handshake
//   busy            : frame in progress
//   overrun         : sticky, a completed word was dropped
module usr_deser
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             dir,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             busy,
   output logic             overrun
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             dir_q;
   logic             shift_en, clr, done;
   logic [WIDTH-1:0] word;

   deser_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (shift_en),
      .dir     (dir_q),
      .sin     (sin),
      .sh_next (word)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // start wins in either state; sin_valid in the start cycle is dropped.
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      clr       = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SHIFT;
               clr       = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (start) begin
               clr = 1'b1;
            end else if (sin_valid) begin
               shift_en = 1'b1;
               if (cnt == LAST) begin
                  done      = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt   <= '0;
         dir_q <= DIR_LSB_FIRST;
      end else if (clr) begin
         cnt   <= '0;
         dir_q <= dir;
      end else if (shift_en) begin
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

   // Output buffer: a completed word is stored if the slot is empty or is
   // being drained this cycle; otherwise it is lost and overrun latches.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (done) begin
         if (!q_valid || q_ready) begin
            q       <= word;
            q_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

   assign busy = (state == ST_SHIFT);
endmodule

// File: tb/tb_usr_deser.sv
module tb_usr_deser;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, start, dir, sin, sin_valid, q_ready;
   logic [W-1:0] q;
   logic         q_valid, busy, overrun;

   usr_deser #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dir       (dir),
      .sin       (sin),
      .sin_valid (sin_valid),
      .q         (q),
      .q_valid   (q_valid),
      .q_ready   (q_ready),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst, st, d, s, sv, rdy;
      logic [W-1:0] eq;
      logic         eqv, eb, eo;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: frame bits collected in a queue, word assembled
   // arithmetically from bit positions at completion.
   bit           m_busy, m_dir, m_qv, m_ovr;
   logic [W-1:0] m_q;
   int           bits[$];

   function automatic void model_step(input logic rst, st, d, s, sv, rdy);
      bit           complete = 0;
      logic [W-1:0] w = '0;
      if (!rst) begin
         m_busy = 0; m_dir = 0; m_qv = 0; m_ovr = 0; m_q = '0;
         bits.delete();
         return;
      end
      if (st) begin
         m_busy = 1; m_dir = d;
         bits.delete();
      end else if (m_busy && sv) begin
         bits.push_back(int'(s));
         if (bits.size() == W) begin
            int acc = 0;
            for (int i = 0; i < W; i++)
               acc += m_dir ? bits[i] * (1 << (W - 1 - i)) : bits[i] * (1 << i);
            w = W'(acc);
            complete = 1;
            m_busy = 0;
            bits.delete();
         end
      end
      if (complete) begin
         if (!m_qv || rdy) begin m_q = w; m_qv = 1; end
         else m_ovr = 1;
      end else if (m_qv && rdy) begin
         m_qv = 0;
      end
   endfunction

   task automatic v(input logic rst, st, d, s, sv, rdy,
                    input logic [W-1:0] eq, input logic eqv, eb, eo);
      vec_t e;
      e.rst = rst; e.st = st; e.d = d; e.s = s; e.sv = sv; e.rdy = rdy;
      e.eq = eq; e.eqv = eqv; e.eb = eb; e.eo = eo;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [W+2:0] act, input logic [W+2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: {q,q_valid,busy,overrun} got %h required %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input logic rst, st, d, s, sv, rdy);
      reset = rst; start = st; dir = d; sin = s; sin_valid = sv; q_ready = rdy;
      @(posedge clk);
      #1;
      model_step(rst, st, d, s, sv, rdy);
   endtask

   initial begin
      reset = 0; start = 0; dir = 0; sin = 0; sin_valid = 0; q_ready = 0;
      #2;
      // reset held with activity on the inputs, then released
      v(0,1,1,1,1,0, 4'h0,0,0,0);
      v(0,1,0,1,1,1, 4'h0,0,0,0);
      v(1,0,0,0,0,0, 4'h0,0,0,0);
      // LSB-first 1,0,1,1 -> D
      v(1,1,0,0,0,0, 4'h0,0,1,0);
      v(1,0,0,1,1,0, 4'h0,0,1,0);
      v(1,0,0,0,1,0, 4'h0,0,1,0);
      v(1,0,0,1,1,0, 4'h0,0,1,0);
      v(1,0,0,1,1,0, 4'hD,1,0,0);
      v(1,0,0,0,0,1, 4'hD,0,0,0);
      // idle strobes ignored; MSB-first 1,0,1,1 with 2-cycle gaps -> B
      v(1,0,0,1,1,0, 4'hD,0,0,0);
      v(1,0,0,0,1,0, 4'hD,0,0,0);
      v(1,1,1,0,0,0, 4'hD,0,1,0);
      v(1,0,0,1,1,0, 4'hD,0,1,0);
      v(1,0,0,0,0,0, 4'hD,0,1,0);
      v(1,0,0,1,0,0, 4'hD,0,1,0);
      v(1,0,0,0,1,0, 4'hD,0,1,0);
      v(1,0,0,1,0,0, 4'hD,0,1,0);
      v(1,0,0,0,0,0, 4'hD,0,1,0);
      v(1,0,0,1,1,0, 4'hD,0,1,0);
      v(1,0,0,0,0,0, 4'hD,0,1,0);
      v(1,0,0,1,0,0, 4'hD,0,1,0);
      v(1,0,0,1,1,0, 4'hB,1,0,0);
      v(1,0,0,0,0,1, 4'hB,0,0,0);
      // D held unconsumed, next word dropped -> overrun
      v(1,1,0,0,0,0, 4'hB,0,1,0);
      v(1,0,0,1,1,0, 4'hB,0,1,0);
      v(1,0,0,0,1,0, 4'hB,0,1,0);
      v(1,0,0,1,1,0, 4'hB,0,1,0);
      v(1,0,0,1,1,0, 4'hD,1,0,0);
      v(1,1,0,0,0,0, 4'hD,1,1,0);
      v(1,0,0,1,1,0, 4'hD,1,1,0);
      v(1,0,0,1,1,0, 4'hD,1,1,0);
      v(1,0,0,0,1,0, 4'hD,1,1,0);
      v(1,0,0,0,1,0, 4'hD,1,0,1);
      // completion with simultaneous consume -> 4, q_valid stays
      v(1,1,0,0,0,0, 4'hD,1,1,1);
      v(1,0,0,0,1,0, 4'hD,1,1,1);
      v(1,0,0,0,1,0, 4'hD,1,1,1);
      v(1,0,0,1,1,0, 4'hD,1,1,1);
      v(1,0,0,0,1,1, 4'h4,1,0,1);
      v(1,0,0,0,0,1, 4'h4,0,0,1);
      // abort after 2 bits; restart cycle has sin_valid high (ignored)
      v(1,1,1,0,0,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(1,1,0,1,1,0, 4'h4,0,1,1);
      v(1,0,0,0,1,0, 4'h4,0,1,1);
      v(1,0,0,0,1,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(1,0,0,0,1,0, 4'h4,1,0,1);
      v(1,0,0,0,0,1, 4'h4,0,0,1);
      // reset mid-frame discards the partial word
      v(1,1,0,0,0,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(1,0,0,1,1,0, 4'h4,0,1,1);
      v(0,0,0,1,1,0, 4'h0,0,0,0);
      v(1,0,0,1,1,0, 4'h0,0,0,0);
      v(1,0,0,0,0,0, 4'h0,0,0,0);

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].st, tbl[i].d, tbl[i].s, tbl[i].sv, tbl[i].rdy);
         check("vec", i, {q, q_valid, busy, overrun},
               {tbl[i].eq, tbl[i].eqv, tbl[i].eb, tbl[i].eo});
         check("vec_model", i, {q, q_valid, busy, overrun}, {m_q, m_qv, m_busy, m_ovr});
      end

      for (int i = 0; i < 3000; i++) begin
         logic rst, st, d, s, sv, rdy;
         rst = ($urandom_range(0, 199) != 0);
         st  = ($urandom_range(0, 19) == 0);
         d   = 1'($urandom);
         s   = 1'($urandom);
         sv  = ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 3) == 0);
         apply(rst, st, d, s, sv, rdy);
         check("rand", i, {q, q_valid, busy, overrun}, {m_q, m_qv, m_busy, m_ovr});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
